// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N-channel leaky integrate-and-fire neuron array.
// Each channel leaks, integrates its input with saturation, and fires against a shared threshold.
// After firing, a channel is held silent by its own refractory counter.
// Optional build macro LIF_SPIKE_COUNT_EN adds per-channel saturating spike counters.
// These counters are read through the cnt_sel / spike_count mux.
// When the macro is undefined, spike_count reads 0.
module lif_neuron_array #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned REF_W     = 8,
  parameter int unsigned RESET_SUB = 0,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         leak_mode,
  input  logic [N_NEURONS*WIDTH-1:0]   input_current,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [WIDTH-1:0]             decay,
  input  logic [REF_W-1:0]             refractory_period,
  output logic [N_NEURONS-1:0]         spike_out,
  input  logic [SEL_W-1:0]             cnt_sel,
  output logic [CNT_W-1:0]             spike_count
);

  logic [WIDTH-1:0] v_q   [N_NEURONS];
  logic [WIDTH-1:0] v_d   [N_NEURONS];
  logic [REF_W-1:0] ref_q [N_NEURONS];
  logic [REF_W-1:0] ref_d [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q, spike_d;

  // Per-channel datapath intermediates
  logic [WIDTH-1:0] lk  [N_NEURONS];
  logic [WIDTH:0]   sum [N_NEURONS];
  logic [WIDTH-1:0] vn  [N_NEURONS];

  // Next-state: refractory countdown, or leak + saturating integrate + fire decision
  always_comb begin
    spike_d = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      v_d[i]   = v_q[i];
      ref_d[i] = ref_q[i];
      if (leak_mode) begin
        lk[i] = v_q[i] - (v_q[i] >> decay[2:0]);
      end else begin
        lk[i] = (v_q[i] > decay) ? v_q[i] - decay : '0;
      end
      sum[i] = {1'b0, lk[i]} + {1'b0, input_current[i*WIDTH +: WIDTH]};
      vn[i]  = sum[i][WIDTH] ? '1 : sum[i][WIDTH-1:0];
      if (enable) begin
        if (ref_q[i] != '0) begin
          ref_d[i] = ref_q[i] - REF_W'(1);
          v_d[i]   = '0;
        end else if (vn[i] >= threshold) begin
          spike_d[i] = 1'b1;
          v_d[i]     = (RESET_SUB != 0) ? vn[i] - threshold : '0;
          ref_d[i]   = refractory_period;
        end else begin
          v_d[i] = vn[i];
        end
      end
    end
  end

  // State registers; spike_d is zero whenever enable is low, so spikes last one edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      spike_q <= spike_d;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= v_d[i];
        ref_q[i] <= ref_d[i];
      end
    end
  end

  assign spike_out = spike_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N_NEURONS];
  logic [CNT_W-1:0] cnt_d [N_NEURONS];

  // Saturating per-channel spike counters
  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (spike_d[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read mux; selects beyond the last channel read as zero
  always_comb begin
    spike_count = '0;
    if (32'(cnt_sel) < N_NEURONS) begin
      spike_count = cnt_q[cnt_sel];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign spike_count    = '0;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed testbench for lif_neuron_array.
// dut0 clears the membrane on a spike and uses 2-bit counters.
// dut1 subtracts the threshold on a spike and uses 8-bit counters.
// Both instances share all inputs.
module tb_lif_neuron_array;

`ifdef LIF_SPIKE_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        leak_mode;
  logic [31:0] input_current;
  logic [7:0]  threshold;
  logic [7:0]  decay;
  logic [7:0]  refractory_period;
  logic [1:0]  cnt_sel;
  logic [3:0]  spike0, spike1;
  logic [1:0]  count0;
  logic [7:0]  count1;

  int checks = 0;
  int errors = 0;

  lif_neuron_array #(
    .N_NEURONS(4), .WIDTH(8), .REF_W(8), .RESET_SUB(0), .CNT_W(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .leak_mode(leak_mode),
    .input_current(input_current), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .spike_out(spike0), .cnt_sel(cnt_sel),
    .spike_count(count0)
  );

  lif_neuron_array #(
    .N_NEURONS(4), .WIDTH(8), .REF_W(8), .RESET_SUB(1), .CNT_W(8)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .leak_mode(leak_mode),
    .input_current(input_current), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .spike_out(spike1), .cnt_sel(cnt_sel),
    .spike_count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic config_case1();
    enable            = 1'b1;
    leak_mode         = 1'b0;
    threshold         = 8'd127;
    decay             = 8'd1;
    refractory_period = 8'd10;
    input_current     = {8'd0, 8'd0, 8'd0, 8'd10};
  endtask

  task automatic test_reset();
    config_case1();
    threshold = 8'd0;
    cnt_sel   = 2'd0;
    reset_n   = 1'b0;
    tick();
    tick();
    checks++;
    if (spike0 !== 4'b0000) begin
      errors++; $display("FAIL reset_spike0: got %b expected 0000", spike0);
    end
    checks++;
    if (spike1 !== 4'b0000) begin
      errors++; $display("FAIL reset_spike1: got %b expected 0000", spike1);
    end
    checks++;
    if (count0 !== 2'd0) begin
      errors++; $display("FAIL reset_count0: got %0d expected 0", count0);
    end
    checks++;
    if (count1 !== 8'd0) begin
      errors++; $display("FAIL reset_count1: got %0d expected 0", count1);
    end
  endtask

  // Case 1: v after enabled edge k is 9k+1; reaches 127 at edge 14.
  // Then 10 refractory edges follow, and the next spike lands 24 edges later at edge 38.
  task automatic test_subtractive_leak();
    config_case1();
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      logic [3:0] exp;
      tick();
      exp = (k == 14 || k == 38) ? 4'b0001 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL subleak edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
  endtask

  // The membrane follows 60,105,139,165,184,198; edge 7 gives vn=209 and fires.
  // After the spike v=0, so the pattern repeats and the next spike lands at edge 14.
  task automatic test_shift_leak();
    enable            = 1'b1;
    leak_mode         = 1'b1;
    threshold         = 8'd200;
    decay             = 8'd2;
    refractory_period = 8'd0;
    input_current     = {8'd0, 8'd0, 8'd60, 8'd0};
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] exp;
      tick();
      exp = (k == 7 || k == 14) ? 4'b0010 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL shiftleak edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
  endtask

  // 200 then 200+200 clamps to 255 and fires; a wrapped 144 would not fire.
  task automatic test_saturation();
    enable            = 1'b1;
    leak_mode         = 1'b0;
    threshold         = 8'd255;
    decay             = 8'd0;
    refractory_period = 8'd0;
    input_current     = {8'd0, 8'd200, 8'd0, 8'd0};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] exp;
      tick();
      exp = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL saturate edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
  endtask

  // Subtract reset: 100, 200->50 fire, 150->0 fire, repeat (spikes at 2,3,5,6).
  // Clear reset: 100, 200->0 fire, 100, ... (spikes at 2,4,6).
  task automatic test_reset_modes();
    enable            = 1'b1;
    leak_mode         = 1'b0;
    threshold         = 8'd150;
    decay             = 8'd0;
    refractory_period = 8'd0;
    input_current     = {8'd100, 8'd0, 8'd0, 8'd0};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] exp0, exp1;
      tick();
      exp0 = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      exp1 = (k % 3 != 1) ? 4'b1000 : 4'b0000;
      checks++;
      if (spike0 !== exp0) begin
        errors++; $display("FAIL clrreset edge %0d: got %b expected %b", k, spike0, exp0);
      end
      checks++;
      if (spike1 !== exp1) begin
        errors++; $display("FAIL subreset edge %0d: got %b expected %b", k, spike1, exp1);
      end
    end
  endtask

  // With threshold 0, every edge fires.
  // Raising the refractory period mid-run then gives fire, two silent edges, fire.
  task automatic test_threshold_zero();
    enable            = 1'b1;
    leak_mode         = 1'b0;
    threshold         = 8'd0;
    decay             = 8'd0;
    refractory_period = 8'd0;
    input_current     = 32'd0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] exp;
      if (k == 4) refractory_period = 8'd2;
      tick();
      exp = (k <= 4 || k == 7) ? 4'b1111 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL thr0 edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
  endtask

  task automatic test_enable_and_reset();
    config_case1();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (spike0 !== 4'b0000) begin
        errors++; $display("FAIL pre_hold edge %0d: got %b expected 0000", k, spike0);
      end
    end
    enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (spike0 !== 4'b0000) begin
        errors++; $display("FAIL disabled edge %0d: got %b expected 0000", k, spike0);
      end
    end
    enable = 1'b1;
    // Membrane was frozen at 91, so enabled edge 14 still fires
    for (int k = 11; k <= 14; k++) begin
      logic [3:0] exp;
      tick();
      exp = (k == 14) ? 4'b0001 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL resume edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
    // Asynchronous reset while the spike is high and refractory is loaded
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (spike0 !== 4'b0000) begin
      errors++; $display("FAIL async_clear: got %b expected 0000", spike0);
    end
    checks++;
    if (count0 !== 2'd0) begin
      errors++; $display("FAIL async_clear_cnt: got %0d expected 0", count0);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] exp;
      tick();
      exp = (k == 14) ? 4'b0001 : 4'b0000;
      checks++;
      if (spike0 !== exp) begin
        errors++; $display("FAIL restart edge %0d: got %b expected %b", k, spike0, exp);
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (spike0 !== 4'b0000) begin
      errors++; $display("FAIL disable_drop: got %b expected 0000", spike0);
    end
  endtask

  // Case 1 fires at edges 14,38,...,182: 8 spikes in 200 edges
  task automatic test_spike_count();
    config_case1();
    cnt_sel = 2'd0;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 14) begin
        checks++;
        if (count0 !== (CntEn ? 2'd1 : 2'd0)) begin
          errors++; $display("FAIL count_first: got %0d expected %0d", count0, CntEn ? 1 : 0);
        end
      end
      if (k == 38) begin
        checks++;
        if (count0 !== (CntEn ? 2'd2 : 2'd0)) begin
          errors++; $display("FAIL count_second: got %0d expected %0d", count0, CntEn ? 2 : 0);
        end
      end
    end
    checks++;
    if (count0 !== (CntEn ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL count_sat: got %0d expected %0d", count0, CntEn ? 3 : 0);
    end
    checks++;
    if (count1 !== (CntEn ? 8'd8 : 8'd0)) begin
      errors++; $display("FAIL count_wide: got %0d expected %0d", count1, CntEn ? 8 : 0);
    end
    cnt_sel = 2'd1;
    #1;
    checks++;
    if (count0 !== 2'd0) begin
      errors++; $display("FAIL count_ch1: got %0d expected 0", count0);
    end
    cnt_sel = 2'd3;
    #1;
    checks++;
    if (count1 !== 8'd0) begin
      errors++; $display("FAIL count_ch3: got %0d expected 0", count1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cnt_sel = 2'd0;
    config_case1();
    test_reset();
    test_subtractive_leak();
    test_shift_leak();
    test_saturation();
    test_reset_modes();
    test_threshold_zero();
    test_enable_and_reset();
    test_spike_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
